branch_predict_unit: RTL
========================

# branch_predict_unit

Execute-stage branch resolution combined with a fetch-stage dynamic predictor: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, parametrised in PC width, table depth and statistics width. Fetch reads a prediction for the current PC. Execute resolves the actual outcome (taken = Jump, or Branch with AluResult[0]; target = AluResult for JALR, else PC+Imm) and compares it against the prediction carried down the pipeline. On mismatch it raises a redirect, then trains the table on the next clock edge. It replaces the purely combinational branch resolver in the pipeline.

## Interface
Parameters:
- PC_W, 9: PC width in bits.
- IDX_W, 4: BTB index width, giving 2^IDX_W entries. Requires PC_W ≥ IDX_W+3.
- CNT_W, 16: statistics counter width.
- Derived: TAG_W = PC_W-IDX_W-2.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; one clock; reset is synchronous and active-high.
- F_PC  in  PC_W  fetch-stage PC.
- F_PredTaken  out  1  fetch prediction: taken.
- F_PredPC  out  32  predicted next PC.
- E_Valid  in  1  execute-stage slot holds a real instruction (0 = bubble/flushed).
- E_PC  in  PC_W  execute-stage PC.
- Imm  in  32  immediate.
- Branch, Jump, Sel_jalr  in  1 each  decode controls.
- AluResult  in  32  bit0 = condition for branches; target for JALR.
- E_PredTaken  in  1  prediction issued at fetch for this instruction, pipelined.
- E_PredPC  in  32  predicted PC issued at fetch for this instruction, pipelined.
- PC_Imm  out  32  zero-extended E_PC + Imm.
- PC_Four  out  32  zero-extended E_PC + 4.
- BrPC  out  32  redirect target.
- PcSel  out  1  redirect request (mispredict).
- Taken  out  1  actual outcome.
- BrCount  out  CNT_W  resolved branches and jumps.
- MissCount  out  CNT_W  mispredicts.

## Operation
BTB structure:
- Entry fields: valid, tag[TAG_W], J (entry is a jump), target[PC_W], ctr[1:0].
- Index = PC[IDX_W+1:2]. Tag = PC[PC_W-1:IDX_W+2].

Fetch lookup (combinational from registered table):
- hit = valid && tag match.
- F_PredTaken = hit && (J || ctr[1]).
- F_PredPC = F_PredTaken ? zero-extended target : zero-extended F_PC+4.

Resolve (combinational):
- isCF = Branch || Jump.
- Taken = E_Valid && (Jump || (Branch && AluResult[0])).
- ActTgt = Sel_jalr ? AluResult : PC_Imm.
- Mispredict when E_Valid and any of:
  - isCF && Taken != E_PredTaken;
  - isCF && Taken && ActTgt != E_PredPC;
  - !isCF && E_PredTaken (tag alias).
- PcSel = Mispredict.
- BrPC = Taken ? ActTgt : PC_Four, including when PcSel=0.

Update (clk edge, only when E_Valid and not reset):
- isCF, existing hit at E_PC: ctr saturating ±1 (taken increments, max 11; not-taken decrements, min 00). J ← Jump. Target ← ActTgt[PC_W-1:0] only if Taken.
- isCF, miss: allocate/overwrite. valid=1, tag, J=Jump, target=ActTgt[PC_W-1:0], ctr = Taken ? 10 : 01.
- !isCF with E_PredTaken and hit: clear that entry's valid.
- BrCount increments when isCF. MissCount increments when Mispredict. Both saturate at all-ones.

Arithmetic:
- PC+Imm and PC+4 are 32-bit, wrapping modulo 2^32.
- Stored target is truncated to PC_W bits.
- JALR AluResult is used unmasked for BrPC and for the E_PredPC comparison.

## Timing
- Resolve outputs (PcSel, BrPC, Taken, PC_Imm, PC_Four): same cycle as execute inputs, zero latency.
- Table write becomes visible to F_PC lookup on the cycle after the update edge. Same-cycle read-during-write returns the old entry.
- Redirect/flush is the pipeline's duty; this block only asserts PcSel for one cycle per mispredicting instruction.
- Reset (synchronous, any time, including mid-branch):
  - at the edge: all valid=0, ctr=01, J=0, targets=0, BrCount=MissCount=0;
  - while reset is high: F_PredTaken=0, PcSel=0, no table or counter update.
  - After reset, F_PredPC = F_PC+4.
- Bubble (E_Valid=0): Taken=0, PcSel=0, no update, counters hold.

## Test plan
- Reset, then F_PC=0x010 -> F_PredTaken=0, F_PredPC=0x14, BrCount=MissCount=0.
- Branch at E_PC=0x020, Imm=0x40, AluResult[0]=1, E_PredTaken=0 -> PcSel=1, BrPC=0x60, MissCount=1. Next cycle F_PC=0x020 -> F_PredTaken=1, F_PredPC=0x60.
- Same branch resolved not-taken three times from ctr=10 -> ctr 01, 00, 00 (saturation). Prediction flips to not-taken after the first; PcSel=1 only on the first resolve.
- JALR at 0x030, AluResult=0x1A4, predicted 0x0F0 taken -> PcSel=1, BrPC=0x1A4. Stored target = 0x1A4 & (2^PC_W-1).
- Alias: non-branch at E_PC with E_PredTaken=1 and hit -> PcSel=1, BrPC=PC_Four, entry invalidated next cycle.
- Reset asserted in the same cycle as a mispredicting branch -> PcSel=0, no update, table cleared. BrCount saturates at 2^CNT_W-1 with CNT_W=4 after 20 branches.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_predict_unit_if : fetch-lookup and execute-resolve signal bundle.
// Rev 1.0
// ----------------------------------------------------------------------------
interface branch_predict_unit_if #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  F_PC;
    logic             F_PredTaken;
    logic [31:0]      F_PredPC;
    logic             E_Valid;
    logic [PC_W-1:0]  E_PC;
    logic [31:0]      Imm;
    logic             Branch;
    logic             Jump;
    logic             Sel_jalr;
    logic [31:0]      AluResult;
    logic             E_PredTaken;
    logic [31:0]      E_PredPC;
    logic [31:0]      PC_Imm;
    logic [31:0]      PC_Four;
    logic [31:0]      BrPC;
    logic             PcSel;
    logic             Taken;
    logic [CNT_W-1:0] BrCount;
    logic [CNT_W-1:0] MissCount;

    // Pipeline side drives PCs and decode controls, consumes predictions/redirects.
    modport master (
        output F_PC, E_Valid, E_PC, Imm, Branch, Jump, Sel_jalr, AluResult,
               E_PredTaken, E_PredPC,
        input  F_PredTaken, F_PredPC, PC_Imm, PC_Four, BrPC, PcSel, Taken,
               BrCount, MissCount
    );

    modport slave (
        input  F_PC, E_Valid, E_PC, Imm, Branch, Jump, Sel_jalr, AluResult,
               E_PredTaken, E_PredPC,
        output F_PredTaken, F_PredPC, PC_Imm, PC_Four, BrPC, PcSel, Taken,
               BrCount, MissCount
    );
endinterface
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_predict_unit : direct-mapped BTB with 2-bit counters plus resolver.
// Rev 1.0
// ----------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int PC_W  = 9,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_predict_unit_if.slave bus
);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] j_q;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [PC_W-1:0]  tgt_q [DEPTH];
    logic [1:0]       ctr_q [DEPTH];
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, f_taken, e_hit;
    logic [31:0]      pc_ext, pc_imm, pc_four, act_tgt;
    logic             is_cf, taken, mispredict;

    logic             wr_en_d;
    logic             wr_valid_d;
    logic             wr_j_d;
    logic [TAG_W-1:0] wr_tag_d;
    logic [PC_W-1:0]  wr_tgt_d;
    logic [1:0]       wr_ctr_d;

    always_comb begin
        f_idx   = bus.F_PC[IDX_W+1:2];
        f_tag   = bus.F_PC[PC_W-1:IDX_W+2];
        f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        f_taken = !reset && f_hit && (j_q[f_idx] || ctr_q[f_idx][1]);
    end

    assign bus.F_PredTaken = f_taken;
    assign bus.F_PredPC    = f_taken ? 32'(tgt_q[f_idx]) : 32'(bus.F_PC) + 32'd4;

    always_comb begin
        pc_ext     = 32'(bus.E_PC);
        pc_imm     = pc_ext + bus.Imm;
        pc_four    = pc_ext + 32'd4;
        is_cf      = bus.Branch || bus.Jump;
        taken      = bus.E_Valid && (bus.Jump || (bus.Branch && bus.AluResult[0]));
        act_tgt    = bus.Sel_jalr ? bus.AluResult : pc_imm;
        e_idx      = bus.E_PC[IDX_W+1:2];
        e_tag      = bus.E_PC[PC_W-1:IDX_W+2];
        e_hit      = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
        // A predicted-taken non-control-flow instruction means a tag alias fooled fetch.
        mispredict = bus.E_Valid &&
                     ((is_cf && ((taken != bus.E_PredTaken) ||
                                 (taken && (act_tgt != bus.E_PredPC)))) ||
                      (!is_cf && bus.E_PredTaken));
    end

    assign bus.PC_Imm    = pc_imm;
    assign bus.PC_Four   = pc_four;
    assign bus.BrPC      = taken ? act_tgt : pc_four;
    assign bus.Taken     = taken;
    assign bus.PcSel     = mispredict && !reset;
    assign bus.BrCount   = br_cnt_q;
    assign bus.MissCount = miss_cnt_q;

    always_comb begin
        wr_en_d    = 1'b0;
        wr_valid_d = valid_q[e_idx];
        wr_j_d     = j_q[e_idx];
        wr_tag_d   = tag_q[e_idx];
        wr_tgt_d   = tgt_q[e_idx];
        wr_ctr_d   = ctr_q[e_idx];
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (bus.E_Valid) begin
            if (is_cf) begin
                wr_en_d    = 1'b1;
                wr_valid_d = 1'b1;
                wr_j_d     = bus.Jump;
                wr_tag_d   = e_tag;
                if (e_hit) begin
                    if (taken && ctr_q[e_idx] != 2'b11) begin
                        wr_ctr_d = ctr_q[e_idx] + 2'd1;
                    end else if (!taken && ctr_q[e_idx] != 2'b00) begin
                        wr_ctr_d = ctr_q[e_idx] - 2'd1;
                    end
                    if (taken) begin
                        wr_tgt_d = act_tgt[PC_W-1:0];
                    end
                end else begin
                    wr_tgt_d = act_tgt[PC_W-1:0];
                    wr_ctr_d = taken ? 2'b10 : 2'b01;
                end
                if (br_cnt_q != {CNT_W{1'b1}}) begin
                    br_cnt_d = br_cnt_q + 1'b1;
                end
            end else if (bus.E_PredTaken && e_hit) begin
                wr_en_d    = 1'b1;
                wr_valid_d = 1'b0;
            end
            if (mispredict && miss_cnt_q != {CNT_W{1'b1}}) begin
                miss_cnt_d = miss_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            j_q        <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            if (wr_en_d) begin
                valid_q[e_idx] <= wr_valid_d;
                j_q[e_idx]     <= wr_j_d;
                tag_q[e_idx]   <= wr_tag_d;
                tgt_q[e_idx]   <= wr_tgt_d;
                ctr_q[e_idx]   <= wr_ctr_d;
            end
        end
    end
endmodule
`default_nettype wire
